// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//
// Ingress controller for one router of the 3-destination packet router.
// Decodes the header address, sequences header / payload / parity loading
// toward the addressed destination FIFO, and throttles the source with busy.
// lfd_state is high for exactly the header byte so each FIFO can tag it.
//
// Moore machine: every output is a pure decode of the state register.
//
// Optional feature (macro ROUTER_FSM_DROP_INVALID_EN):
//   defined   - a header with an address >= NUM_DEST enters DROP_PACKET, where
//               all outputs are low (bytes are consumed and discarded) until
//               the first cycle with pkt_valid low.
//   undefined - such headers leave the FSM parked in DECODE_ADDRESS.
//
// Parameters:
//   ADDR_W    width of the header address field (data_in)
//   NUM_DEST  number of destination FIFOs, must be <= 2**ADDR_W - 1
//
// Ports:
//   clk            system clock, all state on rising edge
//   resetn         synchronous active-low reset
//   pkt_valid      source byte valid (low on the parity byte)
//   data_in        header address bits
//   fifo_full      full flag of the currently addressed FIFO
//   fifo_empty     per-destination empty flags
//   soft_reset     per-destination timeout soft resets
//   parity_done    register block has captured the parity byte
//   low_pkt_valid  register block saw pkt_valid fall while the FIFO was full
//   busy           source must hold the current byte
//   detect_add     header address capture strobe
//   lfd_state      load-first-data (header) cycle
//   ld_state       payload load cycle
//   laf_state      load-after-full cycle
//   full_state     stalled on a full FIFO
//   write_enb_reg  FIFO write enable for the byte held in the register block
//   rst_int_reg    parity check / internal reset pulse
//   dest_addr      latched destination address
// -----------------------------------------------------------------------------
module router_fsm #(
    parameter int ADDR_W   = 2,
    parameter int NUM_DEST = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                busy,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                write_enb_reg,
    output logic                rst_int_reg,
    output logic [ADDR_W-1:0]   dest_addr
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7
`ifdef ROUTER_FSM_DROP_INVALID_EN
        , DROP_PACKET      = 4'd8
`endif
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   dest_addr_reg;

    // One-hot address matches against the live header and the latched
    // address. Addresses >= NUM_DEST match nothing, which makes them invalid
    // and also keeps the fifo_empty select in range.
    logic [NUM_DEST-1:0] live_hit;
    logic [NUM_DEST-1:0] held_hit;
    logic                addr_valid;
    logic                live_empty;
    logic                held_empty;
    logic                load_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEST; gi++) begin : g_addr_match
            assign live_hit[gi] = (data_in       == ADDR_W'(gi));
            assign held_hit[gi] = (dest_addr_reg == ADDR_W'(gi));
        end
    endgenerate

    assign addr_valid = |live_hit;
    assign live_empty = |(live_hit & fifo_empty);
    assign held_empty = |(held_hit & fifo_empty);
    assign load_addr  = (state_reg == DECODE_ADDRESS) && pkt_valid && addr_valid;

    // State and address registers. Soft reset only returns the state to
    // DECODE_ADDRESS; the latched address is left alone.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= DECODE_ADDRESS;
            dest_addr_reg <= '0;
        end else begin
            if (|soft_reset) begin
                state_reg <= DECODE_ADDRESS;
            end else begin
                state_reg <= state_next;
            end
            if (load_addr) begin
                dest_addr_reg <= data_in;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_valid) begin
                    state_next = live_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
`ifdef ROUTER_FSM_DROP_INVALID_EN
                else if (pkt_valid) begin
                    state_next = DROP_PACKET;
                end
`endif
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO wins over a simultaneous pkt_valid fall; the
                // register block remembers the fall via low_pkt_valid.
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                // Uses the latched address: data_in may already carry other
                // bytes while the source is held off.
                if (held_empty) begin
                    state_next = LOAD_FIRST_DATA;
                end
            end
`ifdef ROUTER_FSM_DROP_INVALID_EN
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    state_next = DECODE_ADDRESS;
                end
            end
`endif
            default: state_next = DECODE_ADDRESS;
        endcase
    end

    // Output decode. Unlisted states (DROP_PACKET, illegal codes) drive all
    // outputs low.
    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        case (state_reg)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign dest_addr = dest_addr_reg;

endmodule

// File: tb/tb_router_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_fsm
//
// Randomized packet-level bench for router_fsm. Each stimulus cycle pushes the
// phase the packet is expected to be in (derived from the packet scenario being
// played) onto a scoreboard queue; a monitor pops one entry per cycle and
// compares it to the DUT outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_router_fsm;

    localparam int ADDR_W   = 2;
    localparam int NUM_DEST = 3;

    // Packet phases as seen from the outside
    localparam int P_DEC  = 0;
    localparam int P_LFD  = 1;
    localparam int P_LD   = 2;
    localparam int P_LP   = 3;
    localparam int P_FULL = 4;
    localparam int P_LAF  = 5;
    localparam int P_WAIT = 6;
    localparam int P_CPE  = 7;
    localparam int P_DROP = 8;

    logic                clk;
    logic                resetn;
    logic                pkt_valid;
    logic [ADDR_W-1:0]   data_in;
    logic                fifo_full;
    logic [NUM_DEST-1:0] fifo_empty;
    logic [NUM_DEST-1:0] soft_reset;
    logic                parity_done;
    logic                low_pkt_valid;
    logic                busy;
    logic                detect_add;
    logic                lfd_state;
    logic                ld_state;
    logic                laf_state;
    logic                full_state;
    logic                write_enb_reg;
    logic                rst_int_reg;
    logic [ADDR_W-1:0]   dest_addr;

    router_fsm #(
        .ADDR_W   (ADDR_W),
        .NUM_DEST (NUM_DEST)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .dest_addr     (dest_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ph;
        logic [9:0]  vec;
    } exp_t;

    exp_t        exp_q[$];
    logic [ADDR_W-1:0] m_dest;
    bit          aborted;
    int          cyc_idx;
    int          abort_at;
    bit          stim_done;
    int          n_pkts;

    // Output vector: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, dest}
    function automatic logic [9:0] exp_vec(input int ph, input logic [ADDR_W-1:0] d);
        logic busy_e;
        logic we_e;
        busy_e = !(ph == P_DEC || ph == P_LD || ph == P_DROP);
        we_e   = (ph == P_LD || ph == P_LP || ph == P_LAF);
        return {busy_e, ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_LAF,
                ph == P_FULL, we_e, ph == P_CPE, d};
    endfunction

    // One clock cycle: inputs are already set; record the expected phase for
    // this cycle, optionally fire a planned abort (soft or hard reset).
    task automatic cyc(input int ph);
        bit fire;
        exp_t e;
        fire = (!aborted && abort_at >= 0 && cyc_idx == abort_at);
        if (fire) begin
            if ($urandom_range(0, 1) == 1) begin
                soft_reset = NUM_DEST'($urandom_range(1, 7));
            end else begin
                resetn = 1'b0;
            end
        end
        e.ph  = ph;
        e.vec = exp_vec(ph, m_dest);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (fire) begin
            if (!resetn) m_dest = '0;
            resetn        = 1'b1;
            soft_reset    = '0;
            pkt_valid     = 1'b0;
            fifo_full     = 1'b0;
            parity_done   = 1'b0;
            low_pkt_valid = 1'b0;
            aborted       = 1'b1;
        end
        cyc_idx++;
    endtask

    task automatic rand_empty_except(input int a, input bit v);
        fifo_empty    = NUM_DEST'($urandom);
        fifo_empty[a] = v;
    endtask

    task automatic invalid_packet(input int a);
        int n;
        n = $urandom_range(1, 5);
        pkt_valid = 1'b1;
        data_in   = ADDR_W'(a);
        fifo_full = 1'b0;
`ifdef ROUTER_FSM_DROP_INVALID_EN
        cyc(P_DEC);
        for (int i = 1; i < n; i++) begin
            data_in = ADDR_W'($urandom);
            cyc(P_DROP);
            if (aborted) return;
        end
        pkt_valid = 1'b0;
        cyc(P_DROP);
`else
        for (int i = 0; i < n; i++) begin
            cyc(P_DEC);
            if (aborted) return;
        end
        pkt_valid = 1'b0;
        cyc(P_DEC);
`endif
    endtask

    task automatic run_packet();
        int a;
        bit e;
        int remaining;
        int iter;
        int outcome;
        bit full_now;
        bit go_parity;
        bit cf;

        aborted  = 1'b0;
        cyc_idx  = 0;
        abort_at = -1;

        repeat ($urandom_range(0, 2)) begin
            pkt_valid = 1'b0;
            data_in   = ADDR_W'($urandom);
            fifo_full = 1'($urandom);
            fifo_empty = NUM_DEST'($urandom);
            cyc(P_DEC);
        end

        cyc_idx = 0;
        if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(1, 12);

        a = $urandom_range(0, 3);
        if (a >= NUM_DEST) begin
            invalid_packet(a);
            return;
        end

        // Header
        e = 1'($urandom);
        pkt_valid = 1'b1;
        data_in   = ADDR_W'(a);
        fifo_full = 1'b0;
        rand_empty_except(a, e);
        cyc(P_DEC);
        m_dest = ADDR_W'(a);

        if (!e) begin
            repeat ($urandom_range(1, 5)) begin
                data_in = ADDR_W'($urandom);
                rand_empty_except(a, 1'b0);
                cyc(P_WAIT);
                if (aborted) return;
            end
            data_in = ADDR_W'($urandom);
            rand_empty_except(a, 1'b1);
            cyc(P_WAIT);
            if (aborted) return;
        end

        fifo_full = 1'($urandom);
        cyc(P_LFD);
        if (aborted) return;

        // Payload bytes; the last LOAD_DATA cycle carries the parity byte
        remaining = $urandom_range(1, 6);
        iter      = 0;
        go_parity = 1'b0;
        while (!go_parity) begin
            full_now  = (iter < 8) && ($urandom_range(0, 4) == 0);
            pkt_valid = (remaining > 1);
            data_in   = ADDR_W'($urandom);
            fifo_full = full_now;
            cyc(P_LD);
            if (aborted) return;
            iter++;
            if (full_now) begin
                repeat ($urandom_range(0, 3)) begin
                    cyc(P_FULL);
                    if (aborted) return;
                end
                fifo_full = 1'b0;
                cyc(P_FULL);
                if (aborted) return;
                outcome       = $urandom_range(0, 2);
                parity_done   = (outcome == 0);
                low_pkt_valid = (outcome == 1);
                cyc(P_LAF);
                parity_done   = 1'b0;
                low_pkt_valid = 1'b0;
                if (aborted) return;
                if (outcome == 0) return;
                if (outcome == 1) go_parity = 1'b1;
            end else if (remaining == 1) begin
                go_parity = 1'b1;
            end else begin
                remaining--;
            end
        end

        pkt_valid = 1'b0;
        fifo_full = 1'($urandom);
        cyc(P_LP);
        if (aborted) return;

        cf        = ($urandom_range(0, 3) == 0);
        fifo_full = cf;
        cyc(P_CPE);
        if (aborted) return;
        if (cf) begin
            repeat ($urandom_range(0, 2)) begin
                cyc(P_FULL);
                if (aborted) return;
            end
            fifo_full = 1'b0;
            cyc(P_FULL);
            if (aborted) return;
            parity_done = 1'b1;
            cyc(P_LAF);
            parity_done = 1'b0;
        end
    endtask

    // Stimulus
    initial begin
        stim_done     = 1'b0;
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = '0;
        fifo_full     = 1'b0;
        fifo_empty    = '1;
        soft_reset    = '0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        m_dest        = '0;
        aborted       = 1'b0;
        cyc_idx       = 0;
        abort_at      = -1;
        n_pkts        = 0;

        // Two reset edges; the state after the first one is checked
        @(posedge clk);
        #1;
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        cyc(P_DEC);
        pkt_valid = 1'b0;
        resetn    = 1'b1;

        repeat (80) begin
            run_packet();
            n_pkts++;
        end

        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        cyc(P_DEC);
        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        int   checks;
        int   failures;
        int   cycles;
        exp_t e;
        logic [9:0] act;
        checks   = 0;
        failures = 0;
        cycles   = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {busy, detect_add, lfd_state, ld_state, laf_state,
                       full_state, write_enb_reg, rst_int_reg, dest_addr};
                checks++;
                if (act !== e.vec) begin
                    failures++;
                    $display("FAIL outputs t=%0t phase=%0d actual=%b required=%b (busy,det,lfd,ld,laf,full,we,rst,dest)",
                             $time, e.ph, act, e.vec);
                end
                $display("cycle %0d phase=%0d outputs=%b", cycles, e.ph, act);
            end else if (stim_done) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (cycles > 50000) begin
                failures++;
                $display("FAIL timeout actual=%0d cycles required<=50000", cycles);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Per-router ingress controller for the 3-destination packet router.
- Sits between the source-side input pins and the register/synchronizer/FIFO stages, directly upstream of the destination FIFOs.
- Decodes the packet header address, sequences header/payload/parity loading, and throttles the source via busy.
- Raises lfd_state for exactly the header byte, so each FIFO can tag it (bit 8) and derive its packet byte count.

Parameters:
- ADDR_W, 2, width of the destination address field (header bits [ADDR_W-1:0]).
- NUM_DEST, 3, number of destination FIFOs. Must be ≤ 2**ADDR_W − 1. Addresses ≥ NUM_DEST are invalid.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source asserts for header and payload bytes; deasserts on the parity byte.
- data_in  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently addressed FIFO (muxed by synchronizer).
- fifo_empty  in  NUM_DEST  per-destination empty flags.
- soft_reset  in  NUM_DEST  per-destination timeout soft resets.
- parity_done  in  1  register block has captured the parity byte.
- low_pkt_valid  in  1  register block saw pkt_valid fall while the FIFO was full.
- busy  out  1  source must hold the current byte.
- detect_add  out  1  header address capture strobe.
- lfd_state  out  1  load-first-data (header) cycle.
- ld_state  out  1  payload load cycle.
- laf_state  out  1  load-after-full cycle.
- full_state  out  1  stalled on full FIFO.
- write_enb_reg  out  1  FIFO write enable for the byte held in the register block.
- rst_int_reg  out  1  parity check / internal reset pulse.
- dest_addr  out  ADDR_W  latched destination address.

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register; no other output logic.
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR (+ DROP_PACKET, optional).
- Reset (resetn=0 at edge):
  - state=DECODE_ADDRESS, dest_addr=0.
  - Outputs: detect_add=1, all other outputs 0.
  - Reset mid-packet aborts with no further write_enb_reg.
- Soft reset: any soft_reset bit high at an edge forces state=DECODE_ADDRESS. Lower priority than resetn, higher than every transition.
- DECODE_ADDRESS:
  - dest_addr loads data_in whenever pkt_valid=1 and the address is valid.
  - Go to LOAD_FIRST_DATA if pkt_valid && addr<NUM_DEST && fifo_empty[addr].
  - Go to WAIT_TILL_EMPTY if pkt_valid && addr<NUM_DEST && !fifo_empty[addr].
  - Otherwise hold.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full → FIFO_FULL_STATE.
  - Else !pkt_valid → LOAD_PARITY.
  - Else hold.
  - fifo_full has priority over a simultaneous pkt_valid fall.
- LOAD_PARITY → CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE, else DECODE_ADDRESS.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL, else hold (unbounded).
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - Else low_pkt_valid → LOAD_PARITY.
  - Else → LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty[dest_addr] → LOAD_FIRST_DATA, else hold. Uses the latched address, not live data_in.
- Output decode:
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Latency: header accepted in cycle N (DECODE_ADDRESS) → lfd_state=1 in N+1 → first payload write_enb_reg in N+2.
- Illegal/unused state encodings recover to DECODE_ADDRESS on the next edge.

Optional Feature:
- Macro: ROUTER_FSM_DROP_INVALID_EN.
- Defined:
  - pkt_valid with addr ≥ NUM_DEST in DECODE_ADDRESS → DROP_PACKET.
  - In DROP_PACKET all outputs are 0 (busy=0, so bytes are consumed and discarded).
  - Leaves on the first cycle with pkt_valid=0 → DECODE_ADDRESS. Soft reset also exits.
- Undefined:
  - No DROP_PACKET state exists; invalid-address headers leave the FSM in DECODE_ADDRESS (detect_add=1, busy=0).
  - Such bytes are never written.

Test Plan:
- Reset: resetn=0 two cycles → detect_add=1, busy=0, all other outputs 0, dest_addr=0.
- Normal packet: header addr=1, fifo_empty=3'b111, 4 payload bytes, pkt_valid falls → states DECODE, LFD, LOAD_DATA×4, LOAD_PARITY, CHECK_PARITY; write_enb_reg high exactly 5 cycles; rst_int_reg one pulse.
- Busy destination: addr=2, fifo_empty[2]=0 for 6 cycles → WAIT_TILL_EMPTY, busy=1 for 6 cycles, data_in changed to 0 meanwhile; fifo_empty[2]=1 → LOAD_FIRST_DATA with dest_addr=2.
- Full stall: fifo_full=1 during LOAD_DATA for 3 cycles → full_state=1 for 3 cycles, write_enb_reg=0; release with parity_done=0, low_pkt_valid=1 → LOAD_AFTER_FULL then LOAD_PARITY.
- Soft reset: soft_reset=3'b010 asserted in LOAD_DATA → DECODE_ADDRESS next cycle, detect_add=1, no further write_enb_reg.
- Invalid address 3 with ROUTER_FSM_DROP_INVALID_EN: 5 bytes with pkt_valid=1 → busy=0 and write_enb_reg=0 throughout; DECODE_ADDRESS one cycle after pkt_valid=0. Without the macro: detect_add stays 1 for the whole packet.
